// File: rtl/reg_scoreboard_if.sv
// Decode/writeback-facing bundle of the pending-write scoreboard.
// The master side drives issue, writeback and source queries; the slave side answers with hazards.
interface reg_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
);
  logic                    flush;
  logic                    issue_valid;
  logic [ADDR_W-1:0]       issue_rd;
  logic                    issue_ready;
  logic                    wb_valid;
  logic [ADDR_W-1:0]       wb_rd;
  logic [ADDR_W-1:0]       rs1_addr;
  logic                    rs1_use;
  logic [ADDR_W-1:0]       rs2_addr;
  logic                    rs2_use;
  logic                    rs1_hazard;
  logic                    rs2_hazard;
  logic                    stall;
  logic [CNT_W+ADDR_W-1:0] pending_total;
  logic                    wb_underflow;

  modport master (
    output flush, issue_valid, issue_rd, wb_valid, wb_rd,
           rs1_addr, rs1_use, rs2_addr, rs2_use,
    input  issue_ready, rs1_hazard, rs2_hazard, stall, pending_total, wb_underflow
  );

  modport slave (
    input  flush, issue_valid, issue_rd, wb_valid, wb_rd,
           rs1_addr, rs1_use, rs2_addr, rs2_use,
    output issue_ready, rs1_hazard, rs2_hazard, stall, pending_total, wb_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register outstanding-write counters that turn
// decode source reads into RAW hazards until the producing writeback lands.
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  localparam int TOT_W = CNT_W + ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [1:NUM_REGS-1];
  logic [TOT_W-1:0] r_total;
  logic             r_underflow;

  logic [CNT_W-1:0] w_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_nxt [NUM_REGS];
  logic [CNT_W-1:0] w_cnt_iss;
  logic [CNT_W-1:0] w_cnt_wb;
  logic             w_ready;
  logic             w_issue_acc;
  logic             w_wb_act;
  logic             w_same;
  logic             w_unf;
  logic [TOT_W-1:0] w_sum;

  function automatic logic src_hazard(input logic             use_i,
                                      input logic [ADDR_W-1:0] addr,
                                      input logic [CNT_W-1:0]  cnt,
                                      input logic              wbv,
                                      input logic [ADDR_W-1:0] wrd);
    logic bypass;
    bypass = (WB_BYPASS != 0) && wbv && (wrd == addr) && (cnt == CNT_ONE);
    return use_i && (addr != '0) && (cnt != '0) && !bypass;
  endfunction

  // x0 is modelled as a counter that is permanently zero
  always_comb begin
    w_cnt[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) w_cnt[i] = r_cnt[i];
  end

  assign w_cnt_iss = w_cnt[sb.issue_rd];
  assign w_cnt_wb  = w_cnt[sb.wb_rd];

  // A full counter still accepts an issue when the same register retires this cycle
  assign w_ready = !sb.flush &&
                   !((sb.issue_rd != '0) && (w_cnt_iss == CNT_MAX) &&
                     !(sb.wb_valid && (sb.wb_rd == sb.issue_rd)));

  assign w_issue_acc = sb.issue_valid && w_ready && (sb.issue_rd != '0);
  assign w_wb_act    = sb.wb_valid && (sb.wb_rd != '0);
  assign w_same      = w_issue_acc && w_wb_act && (sb.issue_rd == sb.wb_rd);

  always_comb begin
    w_unf = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) w_nxt[i] = w_cnt[i];
    if (sb.flush) begin
      for (int i = 0; i < NUM_REGS; i++) w_nxt[i] = '0;
    end else if (!w_same) begin
      if (w_issue_acc) w_nxt[sb.issue_rd] = w_cnt_iss + CNT_ONE;
      if (w_wb_act) begin
        if (w_cnt_wb != '0) w_nxt[sb.wb_rd] = w_cnt_wb - CNT_ONE;
        else                w_unf = 1'b1;
      end
    end
    w_sum = '0;
    for (int i = 0; i < NUM_REGS; i++) w_sum = w_sum + TOT_W'(w_nxt[i]);
  end

  // ---- state register stage: counters, running total, underflow pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) r_cnt[i] <= '0;
      r_total     <= '0;
      r_underflow <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) r_cnt[i] <= w_nxt[i];
      r_total     <= w_sum;
      r_underflow <= w_unf;
    end
  end

  assign sb.issue_ready   = w_ready;
  assign sb.rs1_hazard    = src_hazard(sb.rs1_use, sb.rs1_addr, w_cnt[sb.rs1_addr],
                                       sb.wb_valid, sb.wb_rd);
  assign sb.rs2_hazard    = src_hazard(sb.rs2_use, sb.rs2_addr, w_cnt[sb.rs2_addr],
                                       sb.wb_valid, sb.wb_rd);
  assign sb.stall         = sb.rs1_hazard | sb.rs2_hazard;
  assign sb.pending_total = r_total;
  assign sb.wb_underflow  = r_underflow;
endmodule
